// File: rtl/rom_angle_arbiter.sv
// Round-robin arbiter sharing one registered-read angle ROM between NUM_REQ lanes.
// Define ROM_ARB_OUT_REG_EN to add an output register stage (grant-to-response latency 2 instead of 1).
module rom_angle_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 22,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [MEM_WIDTH-1:0]      rsp_data,
    output logic                      rsp_err,
    output logic                      rom_enable,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [MEM_WIDTH-1:0]      rom_dout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] in_range;

    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   win_idx;
    logic               grant_any;
    logic               grant_ok;
    logic               win_in_range;
    logic [NUM_REQ-1:0] grant_vec;

    logic               tag_valid_reg;
    logic [NUM_REQ-1:0] tag_id_reg;
    logic               tag_err_reg;

    logic [NUM_REQ-1:0]   s1_valid;
    logic [MEM_WIDTH-1:0] s1_data;
    logic                 s1_err;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            // Zero-extend so a power-of-two depth treats every address as valid.
            assign in_range[gi] = ({1'b0, addr_arr[gi]} < DEPTH_LIMIT);
        end
    endgenerate

    // Scan from farthest to nearest so the index closest to rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            if (req_valid[scan_sum[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                win_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    assign grant_ok     = grant_any & ~reset;
    assign win_in_range = in_range[win_idx];

    always_comb begin
        grant_vec = '0;
        if (grant_ok)
            grant_vec[win_idx] = 1'b1;
    end

    assign req_ready = grant_vec;

    // Out-of-range grants are accepted but never touch the ROM.
    always_comb begin
        rom_enable  = grant_ok & win_in_range;
        rom_address = '0;
        if (grant_ok && win_in_range)
            rom_address = addr_arr[win_idx];
    end

    always_comb begin
        if (!grant_ok)
            rr_ptr_next = rr_ptr_reg;
        else if (win_idx == PTR_W'(NUM_REQ - 1))
            rr_ptr_next = '0;
        else
            rr_ptr_next = win_idx + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            tag_valid_reg <= 1'b0;
            tag_id_reg    <= '0;
            tag_err_reg   <= 1'b0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            tag_valid_reg <= grant_ok;
            tag_id_reg    <= grant_vec;
            tag_err_reg   <= grant_ok & ~win_in_range;
        end
    end

    // rom_dout is only trusted when the tag says this cycle carries an in-range read.
    always_comb begin
        s1_valid = tag_valid_reg ? tag_id_reg : '0;
        s1_err   = tag_valid_reg & tag_err_reg;
        s1_data  = (tag_valid_reg && !tag_err_reg) ? rom_dout : '0;
    end

`ifdef ROM_ARB_OUT_REG_EN
    logic [NUM_REQ-1:0]   rsp_valid_reg;
    logic [MEM_WIDTH-1:0] rsp_data_reg;
    logic                 rsp_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= s1_valid;
            rsp_data_reg  <= s1_data;
            rsp_err_reg   <= s1_err;
        end
    end

    always_comb begin
        rsp_valid = reset ? '0 : rsp_valid_reg;
        rsp_data  = reset ? '0 : rsp_data_reg;
        rsp_err   = reset ? 1'b0 : rsp_err_reg;
    end
`else
    // A response in flight when reset rises is dropped, not delivered.
    always_comb begin
        rsp_valid = reset ? '0 : s1_valid;
        rsp_data  = reset ? '0 : s1_data;
        rsp_err   = reset ? 1'b0 : s1_err;
    end
`endif

endmodule

// File: tb/tb_rom_angle_arbiter.sv
// Self-checking bench for rom_angle_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural ROM.
`timescale 1ns/1ps
module tb_rom_angle_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 22;
    localparam int AW = 5;
`ifdef ROM_ARB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [W-1:0]    rsp_data, rom_dout;
    logic            rsp_err, rom_enable;
    logic [AW-1:0]   rom_address;

    logic [W-1:0]    rom_mem [0:(1<<AW)-1];

    rom_angle_arbiter #(.NUM_REQ(N), .MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_enable(rom_enable), .rom_address(rom_address), .rom_dout(rom_dout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (rom_enable) rom_dout <= rom_mem[rom_address];

    typedef struct { int due; logic [N-1:0] id; logic err; logic [W-1:0] data; } rsp_t;
    rsp_t pend[$];
    int checks = 0, errors = 0, cyc = 0, m_ptr = 0, e_win;
    logic cur_rst, e_inr, e_en, e_err;
    logic [AW-1:0] e_waddr, e_addr;
    logic [N-1:0] e_ready, e_rv;
    logic [W-1:0] e_data;

    function automatic logic [N*AW-1:0] pack4(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Drive one cycle's inputs and derive what the DUT should show this cycle.
    task automatic set_inputs(input logic rst, input logic [N-1:0] v, input logic [N*AW-1:0] a);
        @(negedge clock);
        reset = rst; req_valid = v; req_addr = a; cur_rst = rst;
        e_win = -1;
        if (!rst)
            for (int k = 0; k < N; k++)
                if (e_win < 0 && v[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
        e_ready = '0; e_waddr = '0; e_inr = 1'b0;
        if (e_win >= 0) begin
            e_ready[e_win] = 1'b1;
            e_waddr = AW'(a >> (e_win * AW));
            e_inr = (int'(e_waddr) < D);
        end
        e_en = (e_win >= 0) && e_inr;
        e_addr = e_en ? e_waddr : '0;
        e_rv = '0; e_err = 1'b0; e_data = '0;
        if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
            e_rv = pend[0].id; e_err = pend[0].err; e_data = pend[0].data;
        end
        #1;
    endtask

    task automatic advance();
        rsp_t r;
        @(posedge clock);
        if (cur_rst) begin
            pend.delete();
            m_ptr = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (e_win >= 0) begin
                r.due = cyc + LAT; r.id = e_ready; r.err = !e_inr;
                r.data = e_inr ? rom_mem[e_waddr] : '0;
                pend.push_back(r);
                m_ptr = (e_win + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin set_inputs(1'b0, '0, '0); advance(); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            set_inputs(i < 3, '1, pack4(0, 1, 2, 3));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL reset_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL reset_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            checks++; if (req_ready !== ((i < 3) ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL reset_grant cyc=%0d got %b want %b", cyc, req_ready, (i < 3) ? 4'b0000 : 4'b0001); end
            advance();
        end
        idle(LAT + 1);
    endtask

    task automatic test_single();
        for (int i = 0; i <= LAT; i++) begin
            set_inputs(1'b0, (i == 0) ? 4'b0010 : 4'b0000, pack4(0, 2, 0, 0));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL single_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL single_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            if (i == LAT) begin
                checks++; if ({rsp_valid, rsp_data} !== {4'b0010, 8'h45}) begin errors++; $display("FAIL single_data got %b/%h want 0010/45", rsp_valid, rsp_data); end
            end
            advance();
        end
    endtask

    task automatic test_all_fair();
        logic [N-1:0] one = 4'b0001;
        set_inputs(1'b0, 4'b1000, '0); advance();  // pointer back to 0
        idle(LAT);
        for (int i = 0; i < 8 + LAT; i++) begin
            set_inputs(1'b0, (i < 8) ? 4'b1111 : 4'b0000, pack4(0, 1, 2, 1));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL fair_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL fair_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            if (i < 8) begin
                checks++; if (req_ready !== (one << (i % 4))) begin errors++; $display("FAIL fair_order i=%0d got %b want %b", i, req_ready, one << (i % 4)); end
            end
            advance();
        end
    endtask

    task automatic test_out_of_range();
        set_inputs(1'b0, 4'b0100, '0); advance();  // pointer to 3
        idle(LAT);
        for (int i = 0; i < 2 + LAT; i++) begin
            set_inputs(1'b0, (i == 0) ? 4'b1001 : ((i == 1) ? 4'b0001 : 4'b0000), pack4(1, 0, 0, 22));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL oor_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL oor_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            if (i == LAT) begin
                checks++; if ({rsp_valid, rsp_err, rsp_data} !== {4'b1000, 1'b1, 8'h00}) begin errors++; $display("FAIL oor_err got %b/%b/%h want 1000/1/00", rsp_valid, rsp_err, rsp_data); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_inputs(i == 1, (i == 0) ? 4'b0100 : ((i == 3) ? 4'b1111 : 4'b0000), pack4(3, 4, 5, 6));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL rmid_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL rmid_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            if (i == 1 || i == 2) begin
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_drop i=%0d got %b want 0000", i, rsp_valid); end
            end
            if (i == 3) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr got %b want 0001", req_ready); end
            end
            advance();
        end
        idle(LAT + 1);
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp_seq [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        set_inputs(1'b0, 4'b0001, '0); advance();  // pointer to 1
        idle(LAT);
        for (int i = 0; i < 4 + LAT; i++) begin
            set_inputs(1'b0, (i < 4) ? 4'b0101 : 4'b0000, pack4(AW'(i), 0, AW'(i + 10), 0));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL alt_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL alt_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            if (i < 4) begin
                checks++; if (req_ready !== exp_seq[i]) begin errors++; $display("FAIL alt_order i=%0d got %b want %b", i, req_ready, exp_seq[i]); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16 + LAT; i++) begin
            set_inputs(1'b0, (i < 16) ? 4'b1111 : 4'b0000,
                       pack4(AW'($urandom_range(0, D-1)), AW'($urandom_range(0, D-1)),
                             AW'($urandom_range(0, D-1)), AW'($urandom_range(0, D-1))));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL b2b_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL b2b_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_inputs($urandom_range(0, 49) == 0, N'($urandom_range(0, 15)), (N*AW)'($urandom));
            checks++; if ({req_ready, rom_enable, rom_address} !== {e_ready, e_en, e_addr}) begin errors++; $display("FAIL rand_drive cyc=%0d got %b/%b/%0d want %b/%b/%0d", cyc, req_ready, rom_enable, rom_address, e_ready, e_en, e_addr); end
            checks++; if ({rsp_valid, rsp_err, rsp_data} !== {e_rv, e_err, e_data}) begin errors++; $display("FAIL rand_rsp cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, rsp_valid, rsp_err, rsp_data, e_rv, e_err, e_data); end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = W'($urandom);
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h02; rom_mem[2] = 8'h45;
        test_reset();
        test_single();
        test_all_fair();
        test_out_of_range();
        test_reset_mid();
        test_alternate();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
